// File: rtl/multi_clk_divider.sv
// multi_clk_divider: per-channel programmable divided clock and period tick.
// Define PHASE_ALIGN_EN to add the sync_i input for aligning channel phases.
module multi_clk_divider #(
  parameter int CHANNELS    = 4,
  parameter int CNT_W       = 32,
  parameter int DEFAULT_DIV = 20,
  parameter int SEL_W       = 2
) (
  input  logic                I_CLK,
  input  logic                Rst,
  input  logic [CHANNELS-1:0] en,
  input  logic                div_wr,
  input  logic [SEL_W-1:0]    div_sel,
  input  logic [CNT_W-1:0]    div_val,
`ifdef PHASE_ALIGN_EN
  input  logic                sync_i,
`endif
  output logic [CNT_W-1:0]    div_rdata,
  output logic [CHANNELS-1:0] O_CLK,
  output logic [CHANNELS-1:0] tick
);

  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(2);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0] shadow_q [CHANNELS];
  logic [CNT_W-1:0] active_q [CHANNELS];
  logic [CNT_W-1:0] cnt_q    [CHANNELS];
  logic [CNT_W-1:0] shadow_d [CHANNELS];
  logic [CNT_W-1:0] active_d [CHANNELS];
  logic [CNT_W-1:0] cnt_d    [CHANNELS];
  logic [CNT_W-1:0] cnt_inc  [CHANNELS];
  logic [CNT_W-1:0] half     [CHANNELS];

  logic [CHANNELS-1:0] wr_hit;
  logic [CHANNELS-1:0] wrap;
  logic [CHANNELS-1:0] clk_d;
  logic [CHANNELS-1:0] tick_d;
  logic [CNT_W-1:0]    wr_val;
  logic [CNT_W-1:0]    rdata_d;
  logic                sync;

`ifdef PHASE_ALIGN_EN
  assign sync = sync_i;
`else
  assign sync = 1'b0;
`endif

  // Decode the divisor write and clamp ratios below 2.
  always_comb begin
    wr_hit = '0;
    wr_val = (div_val < MIN_DIV) ? MIN_DIV : div_val;
    for (int i = 0; i < CHANNELS; i++) begin
      wr_hit[i] = div_wr && (div_sel == SEL_W'(i));
    end
  end

  // Per-channel counter arithmetic: increment, wrap detect, low-phase length.
  always_comb begin
    wrap = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_inc[i] = cnt_q[i] + ONE;
      half[i]    = (active_q[i] >> 1)
                 + {{(CNT_W-1){1'b0}}, active_q[i][0]};
      wrap[i]    = (cnt_q[i] == active_q[i] - ONE);
    end
  end

  // Next state per channel: disable, phase align, or normal counting.
  always_comb begin
    clk_d  = O_CLK;
    tick_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      shadow_d[i] = wr_hit[i] ? wr_val : shadow_q[i];
      active_d[i] = active_q[i];
      cnt_d[i]    = cnt_q[i];
      if (!en[i]) begin
        cnt_d[i]    = '0;
        clk_d[i]    = 1'b0;
        tick_d[i]   = 1'b0;
        active_d[i] = shadow_q[i];
      end else if (sync) begin
        cnt_d[i]    = '0;
        clk_d[i]    = 1'b0;
        tick_d[i]   = 1'b1;
        active_d[i] = shadow_d[i];
      end else if (wrap[i]) begin
        cnt_d[i]    = '0;
        clk_d[i]    = 1'b0;
        tick_d[i]   = 1'b1;
        active_d[i] = shadow_d[i];
      end else begin
        cnt_d[i]    = cnt_inc[i];
        clk_d[i]    = (cnt_inc[i] >= half[i]);
        tick_d[i]   = 1'b0;
      end
    end
  end

  // Readback mux; unmapped selects read as zero.
  always_comb begin
    rdata_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (div_sel == SEL_W'(i)) begin
        rdata_d = active_q[i];
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge I_CLK) begin
    if (Rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_q[i] <= DEF_DIV;
        active_q[i] <= DEF_DIV;
        cnt_q[i]    <= '0;
      end
      O_CLK     <= '0;
      tick      <= '0;
      div_rdata <= DEF_DIV;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      O_CLK     <= clk_d;
      tick      <= tick_d;
      div_rdata <= rdata_d;
    end
  end

endmodule

// File: tb/tb_multi_clk_divider.sv
// tb_multi_clk_divider: directed and random checks against a period model.
// Define PHASE_ALIGN_EN to also exercise sync_i.
module tb_multi_clk_divider;

  localparam int CH = 3;
  localparam int CW = 32;
  localparam int SW = 2;

  logic          clk;
  logic          rst;
  logic [CH-1:0] en;
  logic          wr;
  logic [SW-1:0] sel;
  logic [CW-1:0] val;
  logic          sync;
  logic [CW-1:0] rdata;
  logic [CH-1:0] oclk;
  logic [CH-1:0] tick;

  int n_vec = 0;
  int n_err = 0;

  longint m_shadow [CH];
  longint m_active [CH];
  longint m_age    [CH];
  bit     m_o      [CH];
  bit     m_tick   [CH];
  longint m_rdata;

  multi_clk_divider #(
    .CHANNELS(CH), .CNT_W(CW), .DEFAULT_DIV(20), .SEL_W(SW)
  ) dut (
    .I_CLK    (clk),
    .Rst      (rst),
    .en       (en),
    .div_wr   (wr),
    .div_sel  (sel),
    .div_val  (val),
`ifdef PHASE_ALIGN_EN
    .sync_i   (sync),
`endif
    .div_rdata(rdata),
    .O_CLK    (oclk),
    .tick     (tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Period model: each channel sits at some age within a period of N
  // cycles; it is low for the first ceil(N/2) ages, high for the rest.
  task automatic step_model();
    longint cv;
    longint old_sh;
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        m_shadow[c] = 20;
        m_active[c] = 20;
        m_age[c]    = 0;
        m_o[c]      = 0;
        m_tick[c]   = 0;
      end
      m_rdata = 20;
    end else begin
      m_rdata = (int'(sel) < CH) ? m_active[sel] : 0;
      cv = (longint'(val) < 2) ? 2 : longint'(val);
      for (int c = 0; c < CH; c++) begin
        old_sh = m_shadow[c];
        if (wr && int'(sel) == c) m_shadow[c] = cv;
        if (!en[c]) begin
          m_age[c] = 0; m_o[c] = 0; m_tick[c] = 0;
          m_active[c] = old_sh;
        end else if (sync) begin
          m_age[c] = 0; m_o[c] = 0; m_tick[c] = 1;
          m_active[c] = m_shadow[c];
        end else begin
          m_age[c] = m_age[c] + 1;
          if (m_age[c] == m_active[c]) begin
            m_age[c] = 0; m_o[c] = 0; m_tick[c] = 1;
            m_active[c] = m_shadow[c];
          end else begin
            m_tick[c] = 0;
            m_o[c] = (m_age[c] >= (m_active[c] + 1) / 2);
          end
        end
      end
    end
  endtask

  task automatic cycle();
    logic [CH-1:0] eo;
    logic [CH-1:0] et;
    @(posedge clk);
    step_model();
    #1;
    for (int c = 0; c < CH; c++) begin
      eo[c] = m_o[c];
      et[c] = m_tick[c];
    end
    check("oclk", 64'(oclk), 64'(eo));
    check("tick", 64'(tick), 64'(et));
    check("rdata", 64'(rdata), 64'(m_rdata));
    wr   = 1'b0;
    sync = 1'b0;
  endtask

  task automatic write(input int s, input longint v);
    sel = SW'(s);
    val = CW'(v);
    wr  = 1'b1;
    cycle();
  endtask

  initial begin
    rst = 1'b1; en = '0; wr = 1'b0; sel = '0; val = '0; sync = 1'b0;
    repeat (3) cycle();
    check("rst_oclk", 64'(oclk), 0);
    check("rst_rd", 64'(rdata), 20);

    // Default N=20 on ch0.
    rst = 1'b0; en = 3'b001;
    for (int k = 1; k <= 40; k++) begin
      cycle();
      check("n20_o", 64'(oclk[0]), 64'((k % 20) >= 10));
      check("n20_t", 64'(tick[0]), 64'((k % 20) == 0));
    end
    check("n20_rd", 64'(rdata), 20);

    // ch1 N=5, loaded while disabled.
    write(1, 5);
    cycle();
    en = 3'b011;
    for (int k = 1; k <= 20; k++) begin
      cycle();
      check("n5_o", 64'(oclk[1]), 64'((k % 5) >= 3));
    end

    // Mid-period write to ch0.
    for (int n = 0; n < 40 && m_age[0] != 4; n++) cycle();
    check("wait_age4", 64'(m_age[0]), 4);
    write(0, 8);
    repeat (50) cycle();

    // Write landing on the wrap edge takes effect at once.
    for (int n = 0; n < 40 && m_age[0] != m_active[0] - 1; n++) cycle();
    check("wait_wrap", 64'(m_age[0]), 64'(m_active[0] - 1));
    write(0, 12);
    sel = 2'd0;
    cycle();
    check("bypass_rd", 64'(rdata), 12);
    repeat (15) cycle();

    // Clamping and out-of-range writes.
    write(2, 0);
    write(2, 1);
    cycle();
    en = 3'b111; sel = 2'd2;
    repeat (10) cycle();
    check("clamp_rd", 64'(rdata), 2);
    write(3, 7);
    cycle();
    check("oor_rd", 64'(rdata), 0);

    // Drop enable while high, then restart.
    for (int n = 0; n < 40 && !m_o[0]; n++) cycle();
    check("wait_high", 64'(oclk[0]), 1);
    en[0] = 1'b0;
    cycle();
    check("drop_o", 64'(oclk[0]), 0);
    en[0] = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      cycle();
      check("reen_o", 64'(oclk[0]), 64'(k >= 6));
    end

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 29) == 0) en = en ^ CH'($urandom_range(1, 7));
      wr  = ($urandom_range(0, 3) == 0);
      sel = SW'($urandom_range(0, 3));
      val = CW'($urandom_range(0, 12));
`ifdef PHASE_ALIGN_EN
      sync = ($urandom_range(0, 49) == 0);
`endif
      cycle();
    end
    rst = 1'b0;

    // Largest divisor.
    en = 3'b111;
    write(2, 64'h0000_0000_FFFF_FFFF);
    for (int n = 0; n < 50 && m_active[2] != 64'hFFFF_FFFF; n++) cycle();
    sel = 2'd2;
    repeat (60) cycle();
    check("max_rd", 64'(rdata), 64'hFFFF_FFFF);

    // Reset mid-period.
    repeat (7) cycle();
    rst = 1'b1;
    cycle();
    check("midrst_o", 64'(oclk), 0);
    check("midrst_rd", 64'(rdata), 20);
    rst = 1'b0;
    for (int c = 0; c < CH; c++) begin
      sel = SW'(c);
      cycle();
      check("midrst_div", 64'(rdata), 20);
    end

`ifdef PHASE_ALIGN_EN
    en = 3'b000;
    write(0, 6);
    write(1, 10);
    cycle();
    en = 3'b011;
    repeat (13) cycle();
    sync = 1'b1;
    cycle();
    check("sync_t", 64'(tick[1:0]), 64'h3);
    for (int k = 1; k <= 5; k++) begin
      cycle();
      check("sync_o0", 64'(oclk[0]), 64'(k >= 3));
      check("sync_o1", 64'(oclk[1]), 64'(k >= 5));
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
